note_sequencer: RTL and testbench
=================================

Name: note_sequencer

Overview:
- Record-and-playback note sequencer that produces the 24-bit half-period tone value driving the tone generator.
- Sits directly upstream of the tone generator. It is fed by the edge-detected pushbutton pulses and the rotary decoder outputs.
- The user records a sequence of notes and rests from a fixed 8-note table, then loops it at a tempo set by the rotary wheel.

Parameters:
- DEPTH, 16: maximum number of stored steps.
- ADDR_W, 4: log2(DEPTH).
- TEMPO_DEFAULT, 8250000: clocks per step after reset (0.25 s at 33 MHz).
- TEMPO_STEP, 500000: tempo change per rotary event.
- TEMPO_MIN, 1000000: lower clamp for tempo.
- TEMPO_MAX, 33000000: upper clamp for tempo.

Ports:
- clk  input  1  system clock (33 MHz).
- rst  input  1  synchronous active-high reset.
- rotary_event  input  1  one-cycle pulse per wheel detent.
- rotary_left  input  1  direction, qualified by rotary_event (1 = left).
- btn_play  input  1  pulse; play/pause toggle.
- btn_record  input  1  pulse; enter/exit record mode.
- btn_add_note  input  1  pulse; append the selected note.
- btn_add_rest  input  1  pulse; append a rest.
- btn_clear  input  1  pulse; erase the sequence.
- note_select  input  3  index into the note table.
- tone  output  24  half-period in clocks (0 = silence).
- state_out  output  2  0 IDLE, 1 PLAY, 2 PAUSED, 3 RECORD.
- length  output  ADDR_W+1  number of stored steps (0..DEPTH).
- play_index  output  ADDR_W  current playback step.

Behaviour:
- Reset values: state IDLE, tone 0, length 0, play_index 0, beat counter 0, tempo TEMPO_DEFAULT. Memory contents are don't-care.
- Note table, indices 0..7:
  - 63066 (C4), 56186 (D4), 50056 (E4), 47247 (F4)
  - 42092 (G4), 37500 (A4), 33409 (B4), 31533 (C5)
- Button priority when several pulse in one cycle: clear > record > play > add_note > add_rest. Only the highest-priority button applicable in the current state acts.
- Tempo:
  - Applies in every state. rotary_event with rotary_left=1 adds TEMPO_STEP (slower); rotary_left=0 subtracts it.
  - Result saturates at TEMPO_MAX / TEMPO_MIN. Arithmetic is at least 26 bits with no wrap.
  - Rotary activity and buttons in the same cycle are processed independently.
- IDLE:
  - btn_play with length>0 -> PLAY, play_index=0, beat counter=0. With length==0, no change.
  - btn_record -> RECORD.
  - btn_clear -> length=0.
- PLAY:
  - Beat counter increments each cycle. When counter >= tempo-1, counter=0 and play_index advances.
  - play_index wraps from length-1 to 0. A length of 1 holds index 0.
  - The ">=" comparison handles tempo being lowered below the current count.
  - btn_play -> PAUSED; counter and index hold.
  - btn_clear -> IDLE, length=0, index=0.
  - btn_record, btn_add_note and btn_add_rest are ignored.
- PAUSED:
  - btn_play -> PLAY, resuming the same index and count.
  - btn_clear -> IDLE, length=0, index=0.
  - Other buttons are ignored.
- RECORD:
  - btn_add_note writes table[note_select] at address length, then length+1.
  - btn_add_rest writes 0 at address length, then length+1.
  - When length==DEPTH (full), writes are dropped and length holds.
  - btn_clear -> length=0, stay in RECORD.
  - btn_record -> IDLE.
  - btn_play is ignored.
- tone register:
  - Updates every cycle to mem[play_index] when the next-cycle state is PLAY, and to 0 otherwise.
  - Latency: tone shows the new step one cycle after play_index changes or after entering PLAY.
  - tone is 0 in the cycle the PLAY state is left.
- Reset mid-operation: everything returns to reset values within one cycle, including length=0. Stored data is discarded.
- Memory: synchronous write, asynchronous or combinational read. No read-during-write hazard, because writes occur only in RECORD.

Test Plan:
Simulation uses TEMPO_DEFAULT=10, TEMPO_STEP=2, TEMPO_MIN=4, TEMPO_MAX=20.
1. Record then play: record note 0, rest, note 5, then exit and press play -> length=3. tone cycles 63066, 0, 37500, 63066…, each held 10 cycles, with first 63066 one cycle after play.
2. Pause and resume: pause at step 1, count 4 -> tone 0, index/count frozen for 50 cycles. Press play -> step 1 plays the remaining 6 cycles, then step 2.
3. Full memory: 17 add_note pulses in RECORD -> length saturates at 16, 17th write ignored, playback wraps 15 -> 0.
4. Tempo clamp: 10 right events -> tempo=4. 20 left events -> tempo=20. Lowering tempo mid-step while count=8 -> advance on the next cycle.
5. Simultaneous clear+play in PLAY -> IDLE, length=0, tone 0. Play in IDLE with length 0 -> stays IDLE.
6. rst asserted mid-PLAY -> next cycle state IDLE, tone 0, length 0, tempo 10.

Source files
------------

// File: rtl/note_sequencer.sv
// Record/playback sequencer: stores up to DEPTH notes or rests and loops them at a wheel-set tempo.
// Latency: tone follows play_index (and PLAY entry) by one clock; buttons act on the next edge.
// Backpressure: none; button and rotary pulses are consumed in the cycle they arrive.
module note_sequencer #(
   parameter int unsigned DEPTH         = 16,
   parameter int unsigned ADDR_W        = 4,
   parameter int unsigned TEMPO_DEFAULT = 8250000,
   parameter int unsigned TEMPO_STEP    = 500000,
   parameter int unsigned TEMPO_MIN     = 1000000,
   parameter int unsigned TEMPO_MAX     = 33000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rotary_event,
   input  logic              rotary_left,
   input  logic              btn_play,
   input  logic              btn_record,
   input  logic              btn_add_note,
   input  logic              btn_add_rest,
   input  logic              btn_clear,
   input  logic [2:0]        note_select,
   output logic [23:0]       tone,
   output logic [1:0]        state_out,
   output logic [ADDR_W:0]   length,
   output logic [ADDR_W-1:0] play_index
);

   localparam int unsigned TEMPO_W = 26;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_PLAY   = 2'd1,
      S_PAUSED = 2'd2,
      S_RECORD = 2'd3
   } state_t;

   typedef struct packed {
      logic clear;
      logic record;
      logic play;
      logic add_note;
      logic add_rest;
   } btn_t;

   localparam logic [TEMPO_W:0]   STEP_X    = (TEMPO_W+1)'(TEMPO_STEP);
   localparam logic [TEMPO_W:0]   MAX_X     = (TEMPO_W+1)'(TEMPO_MAX);
   localparam logic [TEMPO_W-1:0] STEP_T    = TEMPO_W'(TEMPO_STEP);
   localparam logic [TEMPO_W-1:0] MIN_T     = TEMPO_W'(TEMPO_MIN);
   localparam logic [TEMPO_W-1:0] MAX_T     = TEMPO_W'(TEMPO_MAX);
   localparam logic [TEMPO_W-1:0] DEF_T     = TEMPO_W'(TEMPO_DEFAULT);
   localparam logic [TEMPO_W-1:0] DN_FLOOR  = TEMPO_W'(TEMPO_MIN + TEMPO_STEP);
   localparam logic [ADDR_W:0]    DEPTH_L   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]    ONE_L     = (ADDR_W+1)'(1);

   function automatic logic [23:0] note_lut(input logic [2:0] sel);
      logic [23:0] v;
      case (sel)
         3'd0:    v = 24'd63066;
         3'd1:    v = 24'd56186;
         3'd2:    v = 24'd50056;
         3'd3:    v = 24'd47247;
         3'd4:    v = 24'd42092;
         3'd5:    v = 24'd37500;
         3'd6:    v = 24'd33409;
         default: v = 24'd31533;
      endcase
      return v;
   endfunction

   state_t              state_q;
   state_t              state_d;
   btn_t                btn;
   logic [23:0]         mem [DEPTH];
   logic [TEMPO_W-1:0]  tempo_q;
   logic [TEMPO_W-1:0]  tempo_d;
   logic [TEMPO_W:0]    tempo_up;
   logic [TEMPO_W-1:0]  beat_cnt;
   logic                full;
   logic                len_zero;

   // Actions resolved from the current state and the winning button.
   logic                clr_len;
   logic                clr_pos;
   logic                start;
   logic                run;
   logic                wr_en;
   logic [23:0]         wr_dat;

   assign btn      = {btn_clear, btn_record, btn_play, btn_add_note, btn_add_rest};
   assign full     = (length == DEPTH_L);
   assign len_zero = (length == '0);

   // Tempo saturates at either end; the up path is one bit wider so it cannot wrap.
   assign tempo_up = {1'b0, tempo_q} + STEP_X;

   always_comb begin
      tempo_d = tempo_q;
      if (rotary_event) begin
         if (rotary_left)
            tempo_d = (tempo_up > MAX_X) ? MAX_T : tempo_up[TEMPO_W-1:0];
         else
            tempo_d = (tempo_q < DN_FLOOR) ? MIN_T : (tempo_q - STEP_T);
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (btn.clear)
               state_d = S_IDLE;
            else if (btn.record)
               state_d = S_RECORD;
            else if (btn.play && !len_zero)
               state_d = S_PLAY;
         end
         S_PLAY: begin
            if (btn.clear)
               state_d = S_IDLE;
            else if (btn.play)
               state_d = S_PAUSED;
         end
         S_PAUSED: begin
            if (btn.clear)
               state_d = S_IDLE;
            else if (btn.play)
               state_d = S_PLAY;
         end
         default: begin
            if (btn.clear)
               state_d = S_RECORD;
            else if (btn.record)
               state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      clr_len   = 1'b0;
      clr_pos   = 1'b0;
      start     = 1'b0;
      run       = 1'b0;
      wr_en     = 1'b0;
      wr_dat    = '0;
      state_out = state_q;
      case (state_q)
         S_IDLE: begin
            if (btn.clear)
               clr_len = 1'b1;
            else if (!btn.record && btn.play && !len_zero)
               start = 1'b1;
         end
         S_PLAY: begin
            if (btn.clear) begin
               clr_len = 1'b1;
               clr_pos = 1'b1;
            end else if (!btn.play) begin
               run = 1'b1;
            end
         end
         S_PAUSED: begin
            if (btn.clear) begin
               clr_len = 1'b1;
               clr_pos = 1'b1;
            end
         end
         default: begin
            if (btn.clear) begin
               clr_len = 1'b1;
            end else if (!btn.record && (btn.add_note || btn.add_rest) && !full) begin
               wr_en  = 1'b1;
               wr_dat = btn.add_note ? note_lut(note_select) : 24'd0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tempo_q    <= DEF_T;
         length     <= '0;
         play_index <= '0;
         beat_cnt   <= '0;
         tone       <= '0;
      end else begin
         tempo_q <= tempo_d;
         // Reads the index held this cycle, so a new step reaches tone one clock later.
         tone    <= (state_d == S_PLAY) ? mem[play_index] : 24'd0;

         if (clr_len)
            length <= '0;
         else if (wr_en)
            length <= length + ONE_L;

         if (clr_pos || start) begin
            play_index <= '0;
            beat_cnt   <= '0;
         end else if (run) begin
            // ">=" lets a freshly lowered tempo end an overlong step at once.
            if (beat_cnt >= tempo_q - TEMPO_W'(1)) begin
               beat_cnt   <= '0;
               play_index <= ({1'b0, play_index} == length - ONE_L) ? '0 : play_index + 1'b1;
            end else begin
               beat_cnt <= beat_cnt + 1'b1;
            end
         end
      end
   end

   // Writes only happen in RECORD, so playback reads never collide with them.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[length[ADDR_W-1:0]] <= wr_dat;
   end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: directed scenarios plus random pulses, checked every cycle
// against a step-level model of the sequencer's rules.
module tb_note_sequencer;

   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int TDEF  = 10;
   localparam int TSTEP = 2;
   localparam int TMIN  = 4;
   localparam int TMAX  = 20;

   localparam logic [4:0] B_CLR  = 5'b10000;
   localparam logic [4:0] B_REC  = 5'b01000;
   localparam logic [4:0] B_PLAY = 5'b00100;
   localparam logic [4:0] B_NOTE = 5'b00010;
   localparam logic [4:0] B_REST = 5'b00001;

   logic          clk = 1'b0;
   logic          rst;
   logic          rotary_event;
   logic          rotary_left;
   logic          btn_play;
   logic          btn_record;
   logic          btn_add_note;
   logic          btn_add_rest;
   logic          btn_clear;
   logic [2:0]    note_select;
   logic [23:0]   tone;
   logic [1:0]    state_out;
   logic [AW:0]   length;
   logic [AW-1:0] play_index;

   always #5 clk = ~clk;

   note_sequencer #(
      .DEPTH(DEPTH), .ADDR_W(AW), .TEMPO_DEFAULT(TDEF),
      .TEMPO_STEP(TSTEP), .TEMPO_MIN(TMIN), .TEMPO_MAX(TMAX)
   ) dut (
      .clk(clk), .rst(rst), .rotary_event(rotary_event), .rotary_left(rotary_left),
      .btn_play(btn_play), .btn_record(btn_record), .btn_add_note(btn_add_note),
      .btn_add_rest(btn_add_rest), .btn_clear(btn_clear), .note_select(note_select),
      .tone(tone), .state_out(state_out), .length(length), .play_index(play_index)
   );

   int n_vec = 0;
   int n_err = 0;
   bit check_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Model: state 0 idle, 1 play, 2 paused, 3 record.
   int tbl [8] = '{63066, 56186, 50056, 47247, 42092, 37500, 33409, 31533};
   int m_mem [DEPTH];
   int m_st = 0, m_len = 0, m_idx = 0, m_cnt = 0, m_tempo = TDEF, m_tone = 0;

   task automatic model_step();
      int ns, nlen, nidx, ncnt, nt;
      if (rst) begin
         m_st = 0; m_len = 0; m_idx = 0; m_cnt = 0; m_tempo = TDEF; m_tone = 0;
         return;
      end
      nt = m_tempo;
      if (rotary_event)
         nt = rotary_left ? ((m_tempo + TSTEP > TMAX) ? TMAX : m_tempo + TSTEP)
                          : ((m_tempo - TSTEP < TMIN) ? TMIN : m_tempo - TSTEP);
      ns = m_st; nlen = m_len; nidx = m_idx; ncnt = m_cnt;
      case (m_st)
         0: if (btn_clear) nlen = 0;
            else if (btn_record) ns = 3;
            else if (btn_play && m_len > 0) begin ns = 1; nidx = 0; ncnt = 0; end
         1: if (btn_clear) begin ns = 0; nlen = 0; nidx = 0; ncnt = 0; end
            else if (btn_play) ns = 2;
            else if (m_cnt >= m_tempo - 1) begin ncnt = 0; nidx = (m_idx + 1) % m_len; end
            else ncnt = m_cnt + 1;
         2: if (btn_clear) begin ns = 0; nlen = 0; nidx = 0; ncnt = 0; end
            else if (btn_play) ns = 1;
         default:
            if (btn_clear) nlen = 0;
            else if (btn_record) ns = 0;
            else if ((btn_add_note || btn_add_rest) && m_len < DEPTH) begin
               m_mem[m_len] = btn_add_note ? tbl[note_select] : 0;
               nlen = m_len + 1;
            end
      endcase
      m_tone = (ns == 1) ? m_mem[m_idx] : 0;
      m_st = ns; m_len = nlen; m_idx = nidx; m_cnt = ncnt; m_tempo = nt;
   endtask

   always @(posedge clk) begin
      model_step();
      #1;
      if (check_en) begin
         check("state", 32'(state_out), 32'(m_st));
         check("tone", 32'(tone), 32'(m_tone));
         check("length", 32'(length), 32'(m_len));
         check("play_index", 32'(play_index), 32'(m_idx));
      end
   end

   task automatic idle(input int n);
      {btn_clear, btn_record, btn_play, btn_add_note, btn_add_rest} = '0;
      rotary_event = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic btn(input logic [4:0] b, input logic [2:0] sel);
      {btn_clear, btn_record, btn_play, btn_add_note, btn_add_rest} = b;
      note_select = sel;
      @(negedge clk);
      {btn_clear, btn_record, btn_play, btn_add_note, btn_add_rest} = '0;
   endtask

   task automatic rot(input logic left);
      rotary_event = 1'b1;
      rotary_left  = left;
      @(negedge clk);
      rotary_event = 1'b0;
   endtask

   initial begin
      int k;
      int idx_before;
      rst = 1'b1;
      rotary_event = 1'b0; rotary_left = 1'b0; note_select = 3'd0;
      {btn_clear, btn_record, btn_play, btn_add_note, btn_add_rest} = '0;
      repeat (2) @(negedge clk);
      check("rst_state", 32'(state_out), 0);
      check("rst_tone", 32'(tone), 0);
      check("rst_length", 32'(length), 0);
      check("rst_index", 32'(play_index), 0);
      rst = 1'b0;
      check_en = 1'b1;

      // Record note 0, rest, note 5, then loop it.
      btn(B_REC, 0); btn(B_NOTE, 0); btn(B_REST, 0); btn(B_NOTE, 5); btn(B_REC, 0);
      check("t1_length", 32'(length), 3);
      check("t1_idle", 32'(state_out), 0);
      btn(B_PLAY, 0);
      check("t1_play_state", 32'(state_out), 1);
      check("t1_first_tone", 32'(tone), 63066);
      idle(10);
      check("t1_tone_held", 32'(tone), 63066);
      idle(1);
      check("t1_rest_tone", 32'(tone), 0);
      idle(10);
      check("t1_a4_tone", 32'(tone), 37500);

      // Pause at step 1, count 4, then resume.
      idle(23);
      btn(B_PLAY, 0);
      check("t2_paused", 32'(state_out), 2);
      check("t2_pause_tone", 32'(tone), 0);
      check("t2_pause_index", 32'(play_index), 1);
      idle(50);
      check("t2_frozen_index", 32'(play_index), 1);
      btn(B_PLAY, 0);
      check("t2_resumed", 32'(state_out), 1);
      idle(5);
      check("t2_remaining", 32'(play_index), 1);
      idle(1);
      check("t2_next_step", 32'(play_index), 2);
      idle(1);
      check("t2_next_tone", 32'(tone), 37500);

      // Clear beats play; play with nothing stored does nothing.
      btn(B_CLR | B_PLAY, 0);
      check("t5_state", 32'(state_out), 0);
      check("t5_length", 32'(length), 0);
      check("t5_tone", 32'(tone), 0);
      btn(B_PLAY, 0);
      check("t5_empty_play", 32'(state_out), 0);

      // Fill the memory past capacity, then play through the wrap.
      btn(B_REC, 0);
      for (int i = 0; i < 17; i++) btn(B_NOTE, 3'($urandom_range(0, 7)));
      check("t3_saturate", 32'(length), 16);
      btn(B_REC, 0);
      btn(B_PLAY, 0);
      idle(180);

      // Tempo clamps, then a cut while the count sits at 8.
      for (int i = 0; i < 10; i++) rot(1'b0);
      idle(30);
      for (int i = 0; i < 20; i++) rot(1'b1);
      idle(60);
      for (int i = 0; i < 5; i++) rot(1'b0);
      idle(1);
      k = 0;
      while (m_cnt != 8 && k < 40) begin idle(1); k++; end
      check("t4_count_reached", 32'(k < 40), 1);
      idx_before = m_idx;
      rot(1'b0);
      idle(1);
      check("t4_advance", 32'(play_index), 32'((idx_before + 1) % 16));

      // Reset in the middle of playback.
      idle(7);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t6_state", 32'(state_out), 0);
      check("t6_tone", 32'(tone), 0);
      check("t6_length", 32'(length), 0);
      check("t6_index", 32'(play_index), 0);
      btn(B_REC, 0); btn(B_NOTE, 1); btn(B_NOTE, 2); btn(B_REC, 0);
      btn(B_PLAY, 0);
      check("t6_first_tone", 32'(tone), 56186);
      idle(10);
      check("t6_tempo_hold", 32'(tone), 56186);
      idle(1);
      check("t6_tempo_step", 32'(tone), 50056);

      // Random pulses on every input.
      for (int c = 0; c < 3000; c++) begin
         rst          = ($urandom_range(0, 999) < 2);
         btn_clear    = ($urandom_range(0, 99) < 2);
         btn_record   = ($urandom_range(0, 99) < 4);
         btn_play     = ($urandom_range(0, 99) < 5);
         btn_add_note = ($urandom_range(0, 99) < 15);
         btn_add_rest = ($urandom_range(0, 99) < 6);
         rotary_event = ($urandom_range(0, 99) < 8);
         rotary_left  = 1'($urandom_range(0, 1));
         note_select  = 3'($urandom_range(0, 7));
         @(negedge clk);
      end
      rst = 1'b0;
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
